apb_master_arbiter: RTL and testbench

Round-robin APB master that shares a single APB slave (the team's APB SRAM) between NUM_REQ local requesters. Each requester posts a read or write command and holds it until a one-cycle response. The block runs the APB IDLE/SETUP/ACCESS sequence on the requester's behalf and returns read data and error status. It sits between the system-side command sources and the APB slave port.

---
 rtl/apb_master_arbiter.sv | 153 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: arbitrates NUM_REQ local command ports onto one APB slave,
// runs IDLE/SETUP/ACCESS/RESP per command and returns a one-cycle response pulse.
module apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int TIMEOUT        = 16
) (
    input  logic                                PCLK,
    input  logic                                PRESET,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*ADDR_BUS_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [DATA_BUS_WIDTH-1:0]           resp_rdata,
    output logic                                resp_err,
    output logic                                busy,
    output logic                                PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [ADDR_BUS_WIDTH-1:0]           PWADDR,
    output logic [DATA_BUS_WIDTH-1:0]           PWDATA,
    input  logic [DATA_BUS_WIDTH-1:0]           PRDATA,
    input  logic                                PREADY,
    input  logic                                PSLVERR
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                      state_r;
    logic [GW-1:0]               last_grant_r;
    logic [GW-1:0]               winner_r;
    logic [CW-1:0]               tmo_cnt_r;

    logic                        any_req_s;
    logic [GW-1:0]               pick_s;
    logic [GW-1:0]               rr_pos_s;
    logic                        pick_write_s;
    logic [ADDR_BUS_WIDTH-1:0]   pick_addr_s;
    logic [DATA_BUS_WIDTH-1:0]   pick_wdata_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] id);
        onehot = NUM_REQ'(1) << id;
    endfunction

    // Round-robin search: first requester after last_grant, wrapping to 0
    always_comb begin
        any_req_s = 1'b0;
        pick_s    = '0;
        rr_pos_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_pos_s  = GW'((int'(last_grant_r) + k) % NUM_REQ);
            pick_s    = (req[rr_pos_s] && !any_req_s) ? rr_pos_s : pick_s;
            any_req_s = any_req_s | req[rr_pos_s];
        end
    end

    assign pick_write_s = req_write[pick_s];
    assign pick_addr_s  = req_addr[int'(pick_s)*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
    assign pick_wdata_s = req_wdata[int'(pick_s)*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];

    // Transfer sequencer; PWRITE/PWADDR/PWDATA double as the latched command
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r      <= ST_IDLE;
            last_grant_r <= LAST_ID;
            winner_r     <= '0;
            tmo_cnt_r    <= '0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PWADDR       <= '0;
            PWDATA       <= '0;
            resp_valid   <= '0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid <= '0;
                    PENABLE    <= 1'b0;
                    if (any_req_s) begin
                        winner_r <= pick_s;
                        PWRITE   <= pick_write_s;
                        PWADDR   <= pick_addr_s;
                        PWDATA   <= pick_wdata_s;
                        PSEL     <= 1'b1;
                        busy     <= 1'b1;
                        state_r  <= ST_SETUP;
                    end else begin
                        PSEL     <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    PSEL      <= 1'b1;
                    PENABLE   <= 1'b1;
                    tmo_cnt_r <= '0;
                    busy      <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        resp_rdata <= PWRITE ? '0 : PRDATA;
                        resp_err   <= PSLVERR;
                        resp_valid <= onehot(winner_r);
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        state_r    <= ST_RESP;
                    end else if (tmo_cnt_r == TO_LAST) begin
                        // Slave never answered: complete with an error so the requester is released
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= onehot(winner_r);
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        state_r    <= ST_RESP;
                    end else begin
                        tmo_cnt_r  <= (tmo_cnt_r == {CW{1'b1}}) ? tmo_cnt_r : tmo_cnt_r + CW'(1);
                        state_r    <= ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    resp_valid   <= '0;
                    last_grant_r <= winner_r;
                    busy         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    PSEL       <= 1'b0;
                    PENABLE    <= 1'b0;
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: 32-word APB SRAM model with registered PREADY,
// directed commands with a response scoreboard checked by an independent monitor.
module tb_apb_master_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic             PCLK = 1'b0;
    logic             PRESET = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    req_write = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_rdata;
    logic             resp_err;
    logic             busy;
    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [AW-1:0]    PWADDR;
    logic [DW-1:0]    PWDATA;
    logic [DW-1:0]    PRDATA;
    logic             PREADY;
    logic             PSLVERR;

    logic [DW-1:0]    mem [32];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    apb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .TIMEOUT(TMO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWADDR(PWADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // SRAM slave: in-range -> PREADY one cycle after ACCESS; out-of-range write -> PSLVERR; out-of-range read -> no PREADY
    always @(posedge PCLK) begin
        if (PRESET) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
        end else if (PSEL && PENABLE && !PREADY) begin
            if (PWADDR < 32'd32) begin
                PREADY  <= 1'b1;
                PSLVERR <= 1'b0;
                if (PWRITE) mem[PWADDR[4:0]] <= PWDATA;
                else        PRDATA <= mem[PWADDR[4:0]];
            end else begin
                PREADY  <= PWRITE;
                PSLVERR <= PWRITE;
            end
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        req_write[id[1:0]]   = wr;
        req_addr[id*AW +: AW] = addr;
        req_wdata[id*DW +: DW] = wd;
        req[id[1:0]]         = 1'b1;
    endtask

    task automatic expect_resp(input int id, input logic [31:0] rd, input logic err, input int at);
        exp_t e;
        e.id = id; e.rdata = rd; e.err = err; e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_resp(input int id, input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge PCLK);
            if (resp_valid[id[1:0]]) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL wait_resp_%0d: no resp_valid within %0d cycles", id, budget);
        end
        req[id[1:0]] = 1'b0;
    endtask

    // Monitor: every response pulse is matched against the oldest expectation
    always @(negedge PCLK) begin
        if (!PRESET && resp_valid != '0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: resp_valid=%b with nothing outstanding", resp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_id",    32'(resp_valid), 32'(4'(1) << mon_e.id));
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_err",   32'(resp_err), 32'(mon_e.err));
                chk("resp_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          c;
        int          j;
        logic [3:0]  served;
        bit          got;

        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_pwaddr", PWADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        PRESET = 1'b0;

        // Read of reset contents
        issue(0, 1'b0, 32'd7, 32'd0);
        expect_resp(0, 32'h07, 1'b0, cyc + 4);
        wait_resp(0, 10);
        @(negedge PCLK);

        // Write with SETUP/ACCESS phase checks
        issue(0, 1'b1, 32'd5, 32'hA5);
        expect_resp(0, 32'd0, 1'b0, cyc + 4);
        @(negedge PCLK);
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_pwrite", 32'(PWRITE), 32'd1);
        chk("setup_pwaddr", PWADDR, 32'd5);
        chk("setup_pwdata", PWDATA, 32'hA5);
        chk("setup_busy", 32'(busy), 32'd1);
        @(negedge PCLK);
        chk("access_psel", 32'(PSEL), 32'd1);
        chk("access_penable", 32'(PENABLE), 32'd1);
        wait_resp(0, 10);
        @(negedge PCLK);

        issue(0, 1'b0, 32'd5, 32'd0);
        expect_resp(0, 32'hA5, 1'b0, cyc + 4);
        wait_resp(0, 10);
        @(negedge PCLK);

        // Contention: all four read, two commands each, fresh round-robin pointer
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        c = cyc;
        for (int i = 0; i < NR; i++) issue(i, 1'b0, 32'(8 + i), 32'd0);
        for (int n = 0; n < 8; n++) expect_resp(n % NR, 32'(8 + n), 1'b0, c + 4 + 5 * n);
        served = '0;
        for (int n = 0; n < 8; n++) begin
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                @(negedge PCLK);
                if (resp_valid != '0) got = 1'b1;
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL contention_wait: response %0d missing", n);
                break;
            end
            j = 0;
            for (int b = NR - 1; b >= 0; b--) if (resp_valid[b]) j = b;
            if (!served[j]) begin
                served[j] = 1'b1;
                req_addr[j*AW +: AW] = 32'(12 + j);
            end else begin
                req[j] = 1'b0;
            end
        end
        req = '0;
        @(negedge PCLK);

        // Out-of-range write: slave error, no memory update
        issue(2, 1'b1, 32'd40, 32'h5A);
        expect_resp(2, 32'd0, 1'b1, cyc + 4);
        wait_resp(2, 10);
        @(negedge PCLK);

        // Out-of-range read: slave silent, forced timeout completion
        issue(2, 1'b0, 32'd40, 32'd0);
        expect_resp(2, 32'd0, 1'b1, cyc + 2 + TMO);
        wait_resp(2, 30);
        @(negedge PCLK);
        chk("tmo_psel_after", 32'(PSEL), 32'd0);
        chk("tmo_busy_after", 32'(busy), 32'd0);

        issue(0, 1'b0, 32'd8, 32'd0);
        expect_resp(0, 32'd8, 1'b0, cyc + 4);
        wait_resp(0, 10);
        @(negedge PCLK);

        // Reset in the middle of an ACCESS: no response, pointer back to requester 0
        issue(0, 1'b1, 32'd3, 32'h33);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("pre_rst_penable", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("midrst_psel", 32'(PSEL), 32'd0);
        chk("midrst_penable", 32'(PENABLE), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        PRESET = 1'b0;
        issue(0, 1'b0, 32'd1, 32'd0);
        issue(2, 1'b0, 32'd2, 32'd0);
        expect_resp(0, 32'd1, 1'b0, cyc + 4);
        expect_resp(2, 32'd2, 1'b0, cyc + 9);
        wait_resp(0, 10);
        wait_resp(2, 10);
        @(negedge PCLK);
        @(negedge PCLK);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
